// File: rtl/instruction_sequencer_if.sv
// Host/sequencer/vector-processor bundle for the instruction sequencer.
// The master side loads the program and pulses start. The slave side is the sequencer itself.
interface instruction_sequencer_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          wr_valid;
    logic [12:0]   wr_instr;
    logic          wr_ready;
    logic          start;
    logic [12:0]   instruction_set;
    logic          issue_valid;
    logic          busy;
    logic          done;
    logic          err_empty;
    logic [CW-1:0] count;

    modport master (
        output wr_valid, wr_instr, start,
        input  wr_ready, instruction_set, issue_valid, busy, done, err_empty, count
    );

    modport slave (
        input  wr_valid, wr_instr, start,
        output wr_ready, instruction_set, issue_valid, busy, done, err_empty, count
    );
endinterface

// File: rtl/instruction_sequencer.sv
// Buffers program words in a circular FIFO and issues them one at a time to the vector processor.
// Each word is held for a per-opcode number of cycles, and successive words follow with no gap.
module instruction_sequencer #(
    parameter int DEPTH    = 16,
    parameter int HOLD_MEM = 3,
    parameter int HOLD_ALU = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    instruction_sequencer_if.slave bus
);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int HMAX = (HOLD_MEM > HOLD_ALU) ? HOLD_MEM : HOLD_ALU;
    localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [12:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [12:0]   instr_q, instr_d;
    logic          issue_q, issue_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          busy_q;
    logic          push, pop;
    logic [12:0]   head;

    assign bus.wr_ready        = (count_q < CW'(DEPTH));
    assign bus.count           = count_q;
    assign bus.instruction_set = instr_q;
    assign bus.issue_valid     = issue_q;
    assign bus.done            = done_q;
    assign bus.err_empty       = err_q;
    assign bus.busy            = busy_q;

    assign push = bus.wr_valid && bus.wr_ready;
    assign head = mem_q[rd_ptr_q];

    // Storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_instr;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        instr_d    = instr_q;
        issue_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                instr_d = '0;
                if (bus.start) begin
                    if (count_q != '0) pop = 1'b1;
                    else               err_d = 1'b1;
                end
            end
            HOLD: begin
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end else if (count_q != '0) begin
                    pop = 1'b1;
                end else begin
                    state_d = DONE;
                    instr_d = '0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                instr_d = '0;
            end
            default: begin
                state_d = IDLE;
                instr_d = '0;
            end
        endcase
        // The issue cycle counts toward the hold time, so load one less than the hold length.
        if (pop) begin
            state_d    = HOLD;
            instr_d    = head;
            issue_d    = 1'b1;
            hold_cnt_d = head[12] ? HW'(HOLD_ALU - 1) : HW'(HOLD_MEM - 1);
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            instr_q    <= '0;
            issue_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            instr_q    <= instr_d;
            issue_q    <= issue_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= (state_d != IDLE);
        end
    end
endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomised self-checking bench for instruction_sequencer.
// Each program is modelled as a flat per-cycle timeline built from the word order and the per-opcode hold lengths.
module tb_instruction_sequencer;
    localparam int DEPTH    = 16;
    localparam int HOLD_MEM = 3;
    localparam int HOLD_ALU = 2;
    localparam int CW       = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [12:0] instr;
        logic        issue;
        logic        busy;
        logic        done;
    } cyc_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    instruction_sequencer_if #(.DEPTH(DEPTH)) bus ();

    instruction_sequencer #(
        .DEPTH   (DEPTH),
        .HOLD_MEM(HOLD_MEM),
        .HOLD_ALU(HOLD_ALU)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic int hold_of(input logic [12:0] w);
        return w[12] ? HOLD_ALU : HOLD_MEM;
    endfunction

    function automatic logic [12:0] rand_word();
        return 13'($urandom);
    endfunction

    // Push each word in consecutive cycles and check the occupancy afterwards.
    task automatic load_words(input string name, input logic [12:0] w[$]);
        for (int i = 0; i < w.size(); i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_instr = w[i];
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
        n_tests++;
        if (bus.count !== CW'(w.size())) begin
            n_fail++;
            $display("FAIL %s load count: got %0d expected %0d", name, bus.count, w.size());
        end
    endtask

    // Pulse start, stream 'extra' words in during the run, and compare every cycle with the timeline.
    task automatic run_program(input string name, input logic [12:0] queued[$],
                               input logic [12:0] extra[$], input int restart_at);
        cyc_t        tl[$];
        logic [12:0] order[$];
        cyc_t        e;
        order = {queued, extra};
        foreach (order[i]) begin
            for (int h = 0; h < hold_of(order[i]); h++) begin
                e.instr = order[i]; e.issue = (h == 0); e.busy = 1'b1; e.done = 1'b0;
                tl.push_back(e);
            end
        end
        e = '{instr: 13'h0, issue: 1'b0, busy: 1'b1, done: 1'b1};
        tl.push_back(e);
        e = '{instr: 13'h0, issue: 1'b0, busy: 1'b0, done: 1'b0};
        tl.push_back(e);
        for (int k = 0; k < tl.size(); k++) begin
            bus.start = (k == 0) || (k == restart_at);
            if (k < extra.size()) begin
                bus.wr_valid = 1'b1;
                bus.wr_instr = extra[k];
            end else begin
                bus.wr_valid = 1'b0;
            end
            @(negedge clk);
            n_tests++;
            if ({bus.instruction_set, bus.issue_valid, bus.busy, bus.done, bus.err_empty} !==
                {tl[k].instr, tl[k].issue, tl[k].busy, tl[k].done, 1'b0}) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got instr=%h iv=%b busy=%b done=%b err=%b, expected instr=%h iv=%b busy=%b done=%b err=0",
                         name, k, bus.instruction_set, bus.issue_valid, bus.busy, bus.done, bus.err_empty,
                         tl[k].instr, tl[k].issue, tl[k].busy, tl[k].done);
            end
        end
        bus.start    = 1'b0;
        bus.wr_valid = 1'b0;
        n_tests++;
        if (bus.count !== '0 || bus.wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s drained: got count=%0d ready=%b expected count=0 ready=1",
                     name, bus.count, bus.wr_ready);
        end
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({bus.instruction_set, bus.issue_valid, bus.busy, bus.done, bus.err_empty, bus.count, bus.wr_ready} !==
            {13'h0, 4'b0, CW'(0), 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got instr=%h iv=%b busy=%b done=%b err=%b count=%0d ready=%b",
                     bus.instruction_set, bus.issue_valid, bus.busy, bus.done, bus.err_empty, bus.count, bus.wr_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.instruction_set !== 13'h0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got instr=%h busy=%b expected 0000 0", bus.instruction_set, bus.busy);
        end
    endtask

    task automatic test_single();
        logic [12:0] q[$];
        q = {13'h0A05};
        load_words("single", q);
        run_program("single", q, '{}, -1);
    endtask

    task automatic test_sequence();
        logic [12:0] q[$];
        q = {13'h1000, 13'h1800, 13'h0A05};
        load_words("sequence", q);
        run_program("sequence", q, '{}, -1);
    endtask

    task automatic test_full();
        logic [12:0] q[$];
        for (int i = 0; i < DEPTH; i++) q.push_back(rand_word());
        load_words("full", q);
        n_tests++;
        if (bus.wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready: got %b expected 0", bus.wr_ready);
        end
        bus.wr_valid = 1'b1;
        bus.wr_instr = 13'h1FFF;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        n_tests++;
        if (bus.count !== CW'(DEPTH) || bus.wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_overflow: got count=%0d ready=%b expected count=%0d ready=0",
                     bus.count, bus.wr_ready, DEPTH);
        end
        run_program("full", q, '{}, -1);
    endtask

    task automatic test_empty_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n_tests++;
        if ({bus.err_empty, bus.busy, bus.instruction_set, bus.issue_valid} !== {1'b1, 1'b0, 13'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL empty_start: got err=%b busy=%b instr=%h iv=%b expected err=1 busy=0 instr=0000 iv=0",
                     bus.err_empty, bus.busy, bus.instruction_set, bus.issue_valid);
        end
        @(negedge clk);
        n_tests++;
        if (bus.err_empty !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_start_pulse: got err=%b busy=%b expected 0 0", bus.err_empty, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] q[$];
        logic [12:0] x[$];
        for (int i = 0; i < 2; i++) q.push_back(rand_word());
        for (int i = 0; i < 6; i++) x.push_back(rand_word());
        load_words("back_to_back", q);
        run_program("back_to_back", q, x, 3);
    endtask

    task automatic test_reset_mid();
        logic [12:0] q[$];
        q = {13'h0A05, 13'h1000, 13'h0801, 13'h1802, 13'h0003};
        load_words("reset_mid", q);
        for (int k = 0; k <= hold_of(q[0]); k++) begin
            bus.start = (k == 0);
            @(negedge clk);
        end
        bus.start = 1'b0;
        n_tests++;
        if (bus.instruction_set !== q[1] || bus.issue_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_second_issue: got instr=%h iv=%b expected instr=%h iv=1",
                     bus.instruction_set, bus.issue_valid, q[1]);
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.instruction_set, bus.count, bus.busy, bus.issue_valid, bus.wr_ready} !==
            {13'h0, CW'(0), 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got instr=%h count=%0d busy=%b iv=%b ready=%b",
                     bus.instruction_set, bus.count, bus.busy, bus.issue_valid, bus.wr_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus.instruction_set !== 13'h0 || bus.issue_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_quiet cycle %0d: got instr=%h iv=%b expected 0000 0",
                         k, bus.instruction_set, bus.issue_valid);
            end
        end
        test_empty_start();
    endtask

    task automatic test_random();
        logic [12:0] q[$];
        logic [12:0] x[$];
        int          nq, nx, rs;
        for (int it = 0; it < 6; it++) begin
            q  = {};
            x  = {};
            nq = int'($urandom_range(1, 4));
            nx = int'($urandom_range(0, 6));
            rs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : -1;
            for (int i = 0; i < nq; i++) q.push_back(rand_word());
            for (int i = 0; i < nx; i++) x.push_back(rand_word());
            load_words($sformatf("random%0d", it), q);
            run_program($sformatf("random%0d", it), q, x, rs);
        end
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_instr = '0;
        bus.start    = 1'b0;
        test_reset();
        test_single();
        test_sequence();
        test_full();
        test_empty_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
